// File: rtl/decode_pkg.sv
// Shared decode definitions: RV32I opcodes, ALU operation encodings and the
// decoded payload bundle passed from the decode stage to the ALU.
package decode_pkg;

  localparam int XLEN_W = 32;
  localparam int ALUCODE_W = 6;
  localparam int REG_ADDR_W = 5;

  // RV32I major opcodes (inst[6:0])
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

  // ALU operation codes as consumed by the ALU
  typedef enum logic [ALUCODE_W-1:0] {
    ALU_LUI  = 6'd0,
    ALU_JAL  = 6'd1,
    ALU_JALR = 6'd2,
    ALU_BEQ  = 6'd3,
    ALU_BNE  = 6'd4,
    ALU_BLT  = 6'd5,
    ALU_BGE  = 6'd6,
    ALU_BLTU = 6'd7,
    ALU_BGEU = 6'd8,
    ALU_LB   = 6'd9,
    ALU_LH   = 6'd10,
    ALU_LW   = 6'd11,
    ALU_LBU  = 6'd12,
    ALU_LHU  = 6'd13,
    ALU_SB   = 6'd14,
    ALU_SH   = 6'd15,
    ALU_SW   = 6'd16,
    ALU_ADD  = 6'd17,
    ALU_SUB  = 6'd18,
    ALU_XOR  = 6'd19,
    ALU_OR   = 6'd20,
    ALU_AND  = 6'd21,
    ALU_SLT  = 6'd22,
    ALU_SLTU = 6'd23,
    ALU_SLL  = 6'd24,
    ALU_SRL  = 6'd25,
    ALU_SRA  = 6'd26,
    ALU_NOP  = 6'd27
  } alu_e;

  // One decoded instruction, field order matches the output port order
  typedef struct packed {
    alu_e                  alucode;
    logic [XLEN_W-1:0]     op1;
    logic [XLEN_W-1:0]     op2;
    logic [REG_ADDR_W-1:0] rd_addr;
    logic                  reg_we;
    logic                  is_load;
    logic                  is_store;
    logic [XLEN_W-1:0]     mem_wdata;
    logic [XLEN_W-1:0]     br_target;
    logic [XLEN_W-1:0]     pc;
    logic                  illegal;
  } payload_t;

  localparam payload_t PAYLOAD_NOP = '{
    alucode:   ALU_NOP,
    op1:       '0,
    op2:       '0,
    rd_addr:   '0,
    reg_we:    1'b0,
    is_load:   1'b0,
    is_store:  1'b0,
    mem_wdata: '0,
    br_target: '0,
    pc:        '0,
    illegal:   1'b0
  };

  // Register/immediate arithmetic op from funct3; alt selects SUB/SRA
  function automatic alu_e alu_arith(input logic [2:0] funct3, input logic alt);
    alu_e op;
    op = ALU_ADD;
    case (funct3)
      3'b000: op = alt ? ALU_SUB : ALU_ADD;
      3'b001: op = ALU_SLL;
      3'b010: op = ALU_SLT;
      3'b011: op = ALU_SLTU;
      3'b100: op = ALU_XOR;
      3'b101: op = alt ? ALU_SRA : ALU_SRL;
      3'b110: op = ALU_OR;
      3'b111: op = ALU_AND;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/decode_comb.sv
// Pure combinational RV32I decoder: instruction, pc and register read data
// in, ALU-ready payload bundle out.
module decode_comb
  import decode_pkg::*;
(
  input  logic [31:0] inst,
  input  logic [31:0] pc,
  input  logic [31:0] rs1_data,
  input  logic [31:0] rs2_data,
  output payload_t    payload
);

  logic [6:0]  opcode;
  logic [4:0]  rd;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [31:0] imm_i;
  logic [31:0] imm_s;
  logic [31:0] imm_b;
  logic [31:0] imm_u;
  logic [31:0] imm_j;
  logic        bad;
  logic        writes_rd;

  assign opcode = inst[6:0];
  assign rd     = inst[11:7];
  assign funct3 = inst[14:12];
  assign funct7 = inst[31:25];

  assign imm_i = {{20{inst[31]}}, inst[31:20]};
  assign imm_s = {{20{inst[31]}}, inst[31:25], inst[11:7]};
  assign imm_b = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
  assign imm_u = {inst[31:12], 12'b0};
  assign imm_j = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};

  // Decode the opcode into operands, ALU op and sideband; unknown encodings become an illegal NOP
  always_comb begin
    // NOTE: every output gets a default first so no path through the case infers a latch.
    payload    = PAYLOAD_NOP;
    payload.pc = pc;
    bad        = 1'b0;
    writes_rd  = 1'b0;

    case (opcode)
      OPC_OP: begin
        payload.op1 = rs1_data;
        payload.op2 = rs2_data;
        writes_rd   = 1'b1;
        if (funct7 == 7'b0000000) begin
          payload.alucode = alu_arith(funct3, 1'b0);
        end else if (funct7 == 7'b0100000 && (funct3 == 3'b000 || funct3 == 3'b101)) begin
          payload.alucode = alu_arith(funct3, 1'b1);
        end else begin
          bad = 1'b1;
        end
      end
      OPC_OP_IMM: begin
        payload.op1 = rs1_data;
        payload.op2 = imm_i;
        writes_rd   = 1'b1;
        // Only the shifts constrain funct7; the ALU reads the shamt from op2[4:0]
        if (funct3 == 3'b001) begin
          payload.alucode = ALU_SLL;
          bad             = (funct7 != 7'b0000000);
        end else if (funct3 == 3'b101) begin
          payload.alucode = alu_arith(funct3, funct7[5]);
          bad             = (funct7 != 7'b0000000) && (funct7 != 7'b0100000);
        end else begin
          payload.alucode = alu_arith(funct3, 1'b0);
        end
      end
      OPC_LUI: begin
        payload.alucode = ALU_LUI;
        payload.op2     = imm_u;
        writes_rd       = 1'b1;
      end
      OPC_AUIPC: begin
        payload.alucode = ALU_ADD;
        payload.op1     = pc;
        payload.op2     = imm_u;
        writes_rd       = 1'b1;
      end
      OPC_JAL: begin
        payload.alucode   = ALU_JAL;
        payload.op2       = pc;
        payload.br_target = pc + imm_j;
        writes_rd         = 1'b1;
      end
      OPC_JALR: begin
        payload.alucode   = ALU_JALR;
        payload.op1       = rs1_data;
        payload.op2       = pc;
        payload.br_target = (rs1_data + imm_i) & ~32'd1;
        writes_rd         = 1'b1;
        bad               = (funct3 != 3'b000);
      end
      OPC_BRANCH: begin
        payload.op1       = rs1_data;
        payload.op2       = rs2_data;
        payload.br_target = pc + imm_b;
        case (funct3)
          3'b000:  payload.alucode = ALU_BEQ;
          3'b001:  payload.alucode = ALU_BNE;
          3'b100:  payload.alucode = ALU_BLT;
          3'b101:  payload.alucode = ALU_BGE;
          3'b110:  payload.alucode = ALU_BLTU;
          3'b111:  payload.alucode = ALU_BGEU;
          default: bad = 1'b1;
        endcase
      end
      OPC_LOAD: begin
        payload.op1     = rs1_data;
        payload.op2     = imm_i;
        payload.is_load = 1'b1;
        writes_rd       = 1'b1;
        case (funct3)
          3'b000:  payload.alucode = ALU_LB;
          3'b001:  payload.alucode = ALU_LH;
          3'b010:  payload.alucode = ALU_LW;
          3'b100:  payload.alucode = ALU_LBU;
          3'b101:  payload.alucode = ALU_LHU;
          default: bad = 1'b1;
        endcase
      end
      OPC_STORE: begin
        payload.op1       = rs1_data;
        payload.op2       = imm_s;
        payload.mem_wdata = rs2_data;
        payload.is_store  = 1'b1;
        case (funct3)
          3'b000:  payload.alucode = ALU_SB;
          3'b001:  payload.alucode = ALU_SH;
          3'b010:  payload.alucode = ALU_SW;
          default: bad = 1'b1;
        endcase
      end
      OPC_MISC_MEM, OPC_SYSTEM: begin
        // Fences and system ops pass through as a legal NOP
      end
      default: bad = 1'b1;
    endcase

    if (bad) begin
      payload         = PAYLOAD_NOP;
      payload.pc      = pc;
      payload.illegal = 1'b1;
    end else if (writes_rd) begin
      payload.rd_addr = rd;
      payload.reg_we  = (rd != 5'd0);
    end
  end

endmodule

// File: rtl/decode_stage.sv
// RV32I decode stage: combinational decode of the fetch payload into a
// registered two-entry skid buffer that feeds the ALU.
module decode_stage
  import decode_pkg::*;
#(
  parameter int XLEN         = 32,
  parameter bit RESET_PC_NOP = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_inst,
  input  logic [XLEN-1:0] in_pc,
  output logic [4:0]      rs1_addr,
  output logic [4:0]      rs2_addr,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [5:0]      alucode,
  output logic [XLEN-1:0] op1,
  output logic [XLEN-1:0] op2,
  output logic [4:0]      rd_addr,
  output logic            reg_we,
  output logic            is_load,
  output logic            is_store,
  output logic [XLEN-1:0] mem_wdata,
  output logic [XLEN-1:0] br_target,
  output logic [XLEN-1:0] out_pc,
  output logic            illegal
);

  typedef enum logic [1:0] {
    ST_EMPTY,
    ST_ONE,
    ST_TWO
  } skid_state_e;

  localparam payload_t RST_PAYLOAD = RESET_PC_NOP ? PAYLOAD_NOP : payload_t'('0);

  skid_state_e state_q, state_d;
  logic        in_ready_q, in_ready_d;
  payload_t    main_q, main_d;
  payload_t    skid_q, skid_d;
  payload_t    dec;
  logic        accept;
  logic        fire;

  assign rs1_addr = in_inst[19:15];
  assign rs2_addr = in_inst[24:20];

  decode_comb u_decode_comb (
    .inst     (in_inst),
    .pc       (in_pc),
    .rs1_data (rs1_data),
    .rs2_data (rs2_data),
    .payload  (dec)
  );

  assign accept = in_valid & in_ready_q;
  assign fire   = out_valid & out_ready;

  // Skid buffer next state: main register always feeds the output, skid absorbs one stalled entry
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;

    case (state_q)
      ST_EMPTY: begin
        if (accept) begin
          main_d  = dec;
          state_d = ST_ONE;
        end
      end
      ST_ONE: begin
        if (accept && fire) begin
          main_d = dec;
        end else if (accept) begin
          skid_d  = dec;
          state_d = ST_TWO;
        end else if (fire) begin
          state_d = ST_EMPTY;
        end
      end
      ST_TWO: begin
        if (fire) begin
          main_d  = skid_q;
          state_d = ST_ONE;
        end
      end
      default: state_d = ST_EMPTY;
    endcase

    // A redirect kills everything, including a same-cycle accept
    if (flush) begin
      state_d = ST_EMPTY;
      main_d  = main_q;
      skid_d  = skid_q;
    end

    in_ready_d = (state_d != ST_TWO);
  end

  // State, ready and payload registers with synchronous reset
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      state_q    <= ST_EMPTY;
      in_ready_q <= 1'b0;
      // NOTE: the payload registers are reset as well so the ALU never sees X data after reset.
      main_q     <= RST_PAYLOAD;
      skid_q     <= RST_PAYLOAD;
    end else begin
      state_q    <= state_d;
      in_ready_q <= in_ready_d;
      main_q     <= main_d;
      skid_q     <= skid_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = (state_q != ST_EMPTY);
  assign alucode   = main_q.alucode;
  assign op1       = main_q.op1;
  assign op2       = main_q.op2;
  assign rd_addr   = main_q.rd_addr;
  assign reg_we    = main_q.reg_we;
  assign is_load   = main_q.is_load;
  assign is_store  = main_q.is_store;
  assign mem_wdata = main_q.mem_wdata;
  assign br_target = main_q.br_target;
  assign out_pc    = main_q.pc;
  assign illegal   = main_q.illegal;

endmodule
